// File: rtl/line_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_pkg : shared types and screen constants for line_arbiter     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package line_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  localparam logic PORT_CLEAR = 1'b0;
  localparam logic PORT_ANIM  = 1'b1;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/coord_clamp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | coord_clamp : limits one x/y point to the visible screen area     |
// | Revision    : 1.0                                                 |
// +------------------------------------------------------------------+
module coord_clamp
  import line_pkg::*;
(
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out
);

  assign x_out = (x_in > X_MAX) ? X_MAX : x_in;
  assign y_out = (y_in > Y_MAX) ? Y_MAX : y_in;

endmodule
`default_nettype wire

// File: rtl/line_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | line_arbiter : two-port priority arbiter feeding one line_drawer  |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
module line_arbiter
  import line_pkg::*;
#(
  parameter int TIMEOUT = 2000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_lock,
  input  logic [X_W-1:0]   req0_x0,
  input  logic [X_W-1:0]   req0_x1,
  input  logic [Y_W-1:0]   req0_y0,
  input  logic [Y_W-1:0]   req0_y1,
  input  logic             req0_color,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [X_W-1:0]   req1_x0,
  input  logic [X_W-1:0]   req1_x1,
  input  logic [Y_W-1:0]   req1_y0,
  input  logic [Y_W-1:0]   req1_y1,
  input  logic             req1_color,
  input  logic             ld_done,
  output logic [X_W-1:0]   ld_x0,
  output logic [X_W-1:0]   ld_x1,
  output logic [Y_W-1:0]   ld_y0,
  output logic [Y_W-1:0]   ld_y1,
  output logic             ld_color,
  output logic             ld_set,
  output logic             owner,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [X_W-1:0]    ld_x0_q, ld_x0_d, ld_x1_q, ld_x1_d;
  logic [Y_W-1:0]    ld_y0_q, ld_y0_d, ld_y1_q, ld_y1_d;
  logic              ld_color_q, ld_color_d;
  logic              owner_q, owner_d;
  logic              timeout_err_q, timeout_err_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  done_cnt0_q, done_cnt0_d, done_cnt1_q, done_cnt1_d;

  logic [X_W-1:0] p0_x0_c, p0_x1_c, p1_x0_c, p1_x1_c;
  logic [Y_W-1:0] p0_y0_c, p0_y1_c, p1_y0_c, p1_y1_c;
  logic           grant0, grant1;

  coord_clamp u_clamp_p0_a (.x_in(req0_x0), .y_in(req0_y0), .x_out(p0_x0_c), .y_out(p0_y0_c));
  coord_clamp u_clamp_p0_b (.x_in(req0_x1), .y_in(req0_y1), .x_out(p0_x1_c), .y_out(p0_y1_c));
  coord_clamp u_clamp_p1_a (.x_in(req1_x0), .y_in(req1_y0), .x_out(p1_x0_c), .y_out(p1_y0_c));
  coord_clamp u_clamp_p1_b (.x_in(req1_x1), .y_in(req1_y1), .x_out(p1_x1_c), .y_out(p1_y1_c));

  // The lock keeps port 1 out even while port 0 has nothing pending.
  assign grant0 = (state_q == S_IDLE) && !reset && req0_valid;
  assign grant1 = (state_q == S_IDLE) && !reset && req1_valid && !req0_valid && !req0_lock;

  always_comb begin
    state_d       = state_q;
    ld_x0_d       = ld_x0_q;
    ld_x1_d       = ld_x1_q;
    ld_y0_d       = ld_y0_q;
    ld_y1_d       = ld_y1_q;
    ld_color_d    = ld_color_q;
    owner_d       = owner_q;
    timeout_err_d = timeout_err_q;
    wait_cnt_d    = wait_cnt_q;
    done_cnt0_d   = done_cnt0_q;
    done_cnt1_d   = done_cnt1_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant0) begin
          req0_ready = 1'b1;
          ld_x0_d    = p0_x0_c;
          ld_x1_d    = p0_x1_c;
          ld_y0_d    = p0_y0_c;
          ld_y1_d    = p0_y1_c;
          ld_color_d = req0_color;
          owner_d    = PORT_CLEAR;
          state_d    = S_ISSUE;
        end else if (grant1) begin
          req1_ready = 1'b1;
          ld_x0_d    = p1_x0_c;
          ld_x1_d    = p1_x1_c;
          ld_y0_d    = p1_y0_c;
          ld_y1_d    = p1_y1_c;
          ld_color_d = req1_color;
          owner_d    = PORT_ANIM;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = WAIT_W'(1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the final timeout cycle still counts as success.
        if (ld_done) begin
          if (owner_q == PORT_CLEAR) begin
            done_cnt0_d = (done_cnt0_q == '1) ? done_cnt0_q : done_cnt0_q + 1'b1;
          end else begin
            done_cnt1_d = (done_cnt1_q == '1) ? done_cnt1_q : done_cnt1_q + 1'b1;
          end
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ld_x0_q       <= '0;
      ld_x1_q       <= '0;
      ld_y0_q       <= '0;
      ld_y1_q       <= '0;
      ld_color_q    <= 1'b0;
      owner_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
      done_cnt0_q   <= '0;
      done_cnt1_q   <= '0;
    end else begin
      state_q       <= state_d;
      ld_x0_q       <= ld_x0_d;
      ld_x1_q       <= ld_x1_d;
      ld_y0_q       <= ld_y0_d;
      ld_y1_q       <= ld_y1_d;
      ld_color_q    <= ld_color_d;
      owner_q       <= owner_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
      done_cnt0_q   <= done_cnt0_d;
      done_cnt1_q   <= done_cnt1_d;
    end
  end

  assign ld_x0       = ld_x0_q;
  assign ld_x1       = ld_x1_q;
  assign ld_y0       = ld_y0_q;
  assign ld_y1       = ld_y1_q;
  assign ld_color    = ld_color_q;
  assign ld_set      = (state_q == S_ISSUE);
  assign owner       = owner_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign done_cnt0   = done_cnt0_q;
  assign done_cnt1   = done_cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_line_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_line_arbiter : directed self-checking bench for line_arbiter   |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module tb_line_arbiter;

  localparam int TIMEOUT = 2000;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_lock, req0_color;
  logic [9:0]  req0_x0, req0_x1;
  logic [8:0]  req0_y0, req0_y1;
  logic        req1_valid, req1_ready, req1_color;
  logic [9:0]  req1_x0, req1_x1;
  logic [8:0]  req1_y0, req1_y1;
  logic        ld_done;
  logic [9:0]  ld_x0, ld_x1;
  logic [8:0]  ld_y0, ld_y1;
  logic        ld_color, ld_set, owner, busy, timeout_err;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req0_x0(req0_x0), .req0_x1(req0_x1), .req0_y0(req0_y0), .req0_y1(req0_y1),
    .req0_color(req0_color),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_x0(req1_x0), .req1_x1(req1_x1), .req1_y0(req1_y0), .req1_y1(req1_y1),
    .req1_color(req1_color),
    .ld_done(ld_done),
    .ld_x0(ld_x0), .ld_x1(ld_x1), .ld_y0(ld_y0), .ld_y1(ld_y1),
    .ld_color(ld_color), .ld_set(ld_set), .owner(owner), .busy(busy),
    .timeout_err(timeout_err), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse ld_done for one cycle starting from S_WAIT.
  task automatic finish_line();
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_done = 1'b0;
    req0_valid = 0; req0_lock = 0; req0_color = 0;
    req0_x0 = 0; req0_x1 = 0; req0_y0 = 0; req0_y1 = 0;
    req1_valid = 0; req1_color = 0;
    req1_x0 = 0; req1_x1 = 0; req1_y0 = 0; req1_y1 = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ld_x0", ld_x0, 0);
    check("rst_owner", owner, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_cnt0", done_cnt0, 0);
    check("rst_cnt1", done_cnt1, 0);

    // 1: single port-1 line
    req1_valid = 1; req1_x0 = 10; req1_y0 = 20; req1_x1 = 30; req1_y1 = 40; req1_color = 1;
    #1;
    check("t1_ready1", req1_ready, 1);
    check("t1_ready0", req0_ready, 0);
    check("t1_set_early", ld_set, 0);
    tick();
    req1_valid = 0;
    check("t1_set", ld_set, 1);
    check("t1_x0", ld_x0, 10);
    check("t1_y0", ld_y0, 20);
    check("t1_x1", ld_x1, 30);
    check("t1_y1", ld_y1, 40);
    check("t1_color", ld_color, 1);
    check("t1_owner", owner, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_set_once", ld_set, 0);
    check("t1_busy_wait", busy, 1);
    repeat (4) tick();
    check("t1_ready_wait", req1_ready, 0);
    finish_line();
    check("t1_idle", busy, 0);
    check("t1_cnt1", done_cnt1, 1);
    check("t1_cnt0", done_cnt0, 0);

    // 2: simultaneous requests, port 0 wins
    req0_valid = 1; req0_x0 = 1; req0_y0 = 2; req0_x1 = 3; req0_y1 = 4; req0_color = 0;
    req1_valid = 1; req1_x0 = 100; req1_y0 = 101; req1_x1 = 102; req1_y1 = 103; req1_color = 1;
    #1;
    check("t2_ready0", req0_ready, 1);
    check("t2_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    #1;
    check("t2_owner", owner, 0);
    check("t2_x0", ld_x0, 1);
    check("t2_color", ld_color, 0);
    check("t2_ready1_issue", req1_ready, 0);
    tick();
    check("t2_ready1_wait", req1_ready, 0);
    finish_line();
    check("t2_cnt0", done_cnt0, 1);
    check("t2_ready1_idle", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("t2_owner1", owner, 1);
    check("t2_x0_p1", ld_x0, 100);
    check("t2_y1_p1", ld_y1, 103);
    tick();
    finish_line();
    check("t2_cnt1", done_cnt1, 2);

    // 3: lock blocks port 1 even with port 0 idle
    req0_lock = 1; req1_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3_lock_ready1", req1_ready, 0);
      tick();
    end
    check("t3_lock_busy", busy, 0);
    req0_lock = 0;
    #1;
    check("t3_unlock_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    tick();
    finish_line();
    check("t3_cnt1", done_cnt1, 3);

    // done on the final timeout cycle: done wins
    req1_valid = 1;
    tick();
    req1_valid = 0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("tc_busy_last", busy, 1);
    finish_line();
    check("tc_idle", busy, 0);
    check("tc_terr", timeout_err, 0);
    check("tc_cnt1", done_cnt1, 4);

    // 4: timeout
    req1_valid = 1;
    tick();
    req1_valid = 0;
    tick();
    repeat (TIMEOUT - 1) tick();
    check("t4_busy_before", busy, 1);
    check("t4_terr_before", timeout_err, 0);
    tick();
    check("t4_idle", busy, 0);
    check("t4_terr", timeout_err, 1);
    check("t4_cnt1", done_cnt1, 4);
    check("t4_cnt0", done_cnt0, 1);
    finish_line();
    check("t4_idle_done_cnt1", done_cnt1, 4);
    check("t4_idle_done_cnt0", done_cnt0, 1);
    tick();
    check("t4_terr_sticky", timeout_err, 1);

    // 5a: clamping
    req0_valid = 1; req0_x0 = 640; req0_y0 = 479; req0_x1 = 700; req0_y1 = 500; req0_color = 1;
    tick();
    req0_valid = 0;
    check("t5_x0", ld_x0, 639);
    check("t5_y0", ld_y0, 479);
    check("t5_x1", ld_x1, 639);
    check("t5_y1", ld_y1, 479);
    tick();

    // 6: reset during S_WAIT
    reset = 1;
    tick();
    reset = 0;
    check("t6_busy", busy, 0);
    check("t6_x1", ld_x1, 0);
    check("t6_y1", ld_y1, 0);
    check("t6_color", ld_color, 0);
    check("t6_terr", timeout_err, 0);
    check("t6_cnt0", done_cnt0, 0);
    check("t6_cnt1", done_cnt1, 0);
    finish_line();
    check("t6_late_done", done_cnt0, 0);
    check("t6_late_busy", busy, 0);

    // 5b: locked clear-screen burst, port 1 waiting throughout
    req0_lock = 1; req1_valid = 1; req0_color = 0;
    for (int y = 0; y < 480; y++) begin
      req0_valid = 1; req0_x0 = 0; req0_x1 = 639; req0_y0 = 9'(y); req0_y1 = 9'(y);
      #1;
      check("t5b_ready0", req0_ready, 1);
      check("t5b_ready1", req1_ready, 0);
      tick();
      req0_valid = 0;
      check("t5b_y0", ld_y0, y);
      tick();
      finish_line();
    end
    check("t5b_cnt0", done_cnt0, 480);
    check("t5b_cnt1", done_cnt1, 0);
    req0_lock = 0;
    #1;
    check("t5b_release", req1_ready, 1);
    req1_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
